// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Instruction-memory writer. Receives a byte stream over a
//            valid/ready handshake framed as LEN_HI, LEN_LO (big-endian word
//            count N) followed by 4*N big-endian data bytes, assembles 32-bit
//            words and issues one write strobe per word. Holds the core via
//            cpu_hold while loading.
//            Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CKSUM  = 3'd6;
    // After the payload the checksum byte must still be consumed
    localparam logic [2:0] S_TAIL   = S_CKSUM;
`else
    localparam logic [2:0] S_TAIL   = S_FIN;
`endif

    localparam logic [ADDR_W:0] C_DEPTH_WL  = (ADDR_W+1)'(DEPTH);
    localparam logic [15:0]     C_DEPTH_LEN = 16'(DEPTH);

    logic [2:0]        r_state;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_rem;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_asm;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
    logic              r_ck_bad;
`endif

    logic              w_ready;
    logic              w_accept;
    logic [15:0]       w_len;

    // Ready is a pure function of state so it never lags the FSM
    assign w_ready  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                      (r_state == S_CKSUM) ||
`endif
                      (r_state == S_DATA);
    assign w_accept = byte_valid & w_ready;
    assign w_len    = {r_len_hi, byte_in};

    // Frame parser, word assembler and write-strobe generator
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len_hi   <= 8'd0;
            r_rem      <= 16'd0;
            r_bcnt     <= 2'd0;
            r_asm      <= 24'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 32'd0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
            r_ck_bad   <= 1'b0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_LEN_HI;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_words    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor      <= 8'd0;
                        r_ck_bad   <= 1'b0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len_hi <= byte_in;
                        r_state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_rem  <= w_len;
                        r_bcnt <= 2'd0;
                        if (w_len > C_DEPTH_LEN) begin
                            r_err <= 1'b1;
                        end
                        r_state <= (w_len == 16'd0) ? S_TAIL : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ byte_in;
`endif
                        r_bcnt <= r_bcnt + 2'd1;
                        r_asm  <= {r_asm[15:0], byte_in};
                        if (r_bcnt == 2'd3) begin
                            // Words past the array end are drained, not written
                            if (r_words < C_DEPTH_WL) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_words[ADDR_W-1:0];
                                r_wr_data <= {r_asm, byte_in};
                                r_words   <= r_words + 1'b1;
                            end
                            r_rem <= r_rem - 16'd1;
                            if (r_rem == 16'd1) begin
                                r_state <= S_TAIL;
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CKSUM: begin
                    if (w_accept) begin
                        r_ck_bad <= (byte_in != r_xor);
                        r_state  <= S_FIN;
                    end
                end
`endif
                S_FIN: begin
                    // One settling cycle so the final write lands before done
                    r_done     <= 1'b1;
                    r_cpu_hold <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (r_ck_bad) begin
                        r_err <= 1'b1;
                    end
`endif
                    r_state    <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready   = w_ready;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader (default build, no checksum).
//            Expected writes are computed from the frame contents directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'd0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int total = 0;
    int bad   = 0;

    logic [7:0]  frame_data[$];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] mem[DEPTH];

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every write strobe as the memory array would see it
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(32'(wr_addr));
            wq_data.push_back(wr_data);
            mem[wr_addr] = wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte, optionally after idle cycles, and wait for its transfer
    task automatic send_byte(input logic [7:0] b, input int gap, input bit in_data);
        bit ok;
        bit rdy;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            if (in_data) chk("ready_in_gap", 32'(byte_ready), 32'd1);
            @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            rdy = (byte_ready === 1'b1);
            @(posedge clk);
            @(negedge clk);
            if (rdy) ok = 1'b1;
        end
        if (!ok) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_on_start", 32'(cpu_hold), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        chk("err_cleared", 32'(err), 32'd0);
        chk("words_cleared", 32'(words_loaded), 32'd0);
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    // mode: 0 = valid held high, 1 = valid toggles, 2 = random gaps
    task automatic run_load(input int n, input int mode, input bit inject_start);
        int exp_writes;
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        send_byte(8'(n >> 8), pick_gap(mode), 1'b0);
        send_byte(8'(n), pick_gap(mode), 1'b0);
        for (int i = 0; i < 4 * n; i++) begin
            if (inject_start && i == 1) start = 1'b1;
            send_byte(frame_data[i], pick_gap(mode), 1'b1);
            start = 1'b0;
        end
        // First negedge after the final accepting edge
        chk("done_early", 32'(done), 32'd0);
        chk("last_wr_en", 32'(wr_en), (n > 0 && n <= DEPTH) ? 32'd1 : 32'd0);
        byte_valid = 1'b0;
        @(negedge clk);
        exp_writes = (n < DEPTH) ? n : DEPTH;
        chk("done", 32'(done), 32'd1);
        chk("err", 32'(err), (n > DEPTH) ? 32'd1 : 32'd0);
        chk("words_loaded", 32'(words_loaded), 32'(exp_writes));
        chk("hold_released", 32'(cpu_hold), 32'd0);
        chk("ready_in_done", 32'(byte_ready), 32'd0);
        chk("n_writes", 32'(wq_addr.size()), 32'(exp_writes));
        for (int w = 0; w < exp_writes && w < wq_addr.size(); w++) begin
            chk("wr_addr", wq_addr[w], 32'(w));
            chk("wr_data", wq_data[w], {frame_data[4*w], frame_data[4*w+1],
                                        frame_data[4*w+2], frame_data[4*w+3]});
        end
        repeat (2) @(negedge clk);
        chk("no_extra_wr", 32'(wq_addr.size()), 32'(exp_writes));
    endtask

    task automatic random_frame(input int n);
        frame_data.delete();
        for (int i = 0; i < 4 * n; i++) frame_data.push_back(8'($urandom));
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);

        // Reference program, valid held high then toggling
        frame_data = '{8'h31, 8'hE9, 8'h00, 8'h04, 8'h31, 8'hEA, 8'h00, 8'h06,
                       8'h31, 8'hEB, 8'h00, 8'h07};
        run_load(3, 0, 1'b0);
        chk("mem0", mem[0], 32'h31E90004);
        chk("mem2", mem[2], 32'h31EB0007);
        run_load(3, 1, 1'b0);

        // Empty program
        run_load(0, 0, 1'b0);

        // Overlong program: tail words are drained without writes
        random_frame(34);
        run_load(34, 0, 1'b0);

        // Reset mid-load after six data bytes
        frame_data = '{8'h31, 8'hE9, 8'h00, 8'h04, 8'h31, 8'hEA, 8'h00, 8'h06,
                       8'h31, 8'hEB, 8'h00, 8'h07};
        mem[0] = 32'h0;
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(frame_data[i], 0, 1'b1);
        byte_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_data", wr_data, 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_words", 32'(words_loaded), 32'd0);
        chk("mid_rst_mem0", mem[0], 32'h31E90004);
        reset = 1'b0;
        @(negedge clk);
        run_load(3, 0, 1'b0);

        // Randomised programs with random gaps; one with a stray start mid-frame
        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(0, 40));
            random_frame(n);
            run_load(n, 2, (k == 2) && (n > 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
